// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// One operation is in flight at a time; requests made while BUSY are dropped.
module mult_div_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       MD_OP,
   input  logic             START,
   output logic             BUSY,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DONE
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [3:0]         op_q, op_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic [2*WIDTH-1:0] prod_s, prod_u, acc;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

   // Datapath operates on latched operands only, so A/B may change during RUN.
   always_comb begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      acc    = {hi_q, lo_q};
      a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
      b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
      a_mag  = a_neg ? -a_q : a_q;
      b_mag  = b_neg ? -b_q : b_q;
      // Sign-magnitude division keeps most-negative / -1 well defined.
      b_safe = (b_q == '0) ? WIDTH'(1) : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem    = a_neg ? -r_mag : r_mag;
   end

   // Next-state and register updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               case (MD_OP)
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                     a_d     = A;
                     b_d     = B;
                     op_d    = MD_OP;
                     cnt_d   = CNT_W'(MULT_LAT - 1);
                     busy_d  = 1'b1;
                     state_d = S_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     a_d     = A;
                     b_d     = B;
                     op_d    = MD_OP;
                     cnt_d   = CNT_W'(DIV_LAT - 1);
                     busy_d  = 1'b1;
                     state_d = S_RUN;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_MADD:  {hi_d, lo_d} = acc + prod_s;
                  OP_MADDU: {hi_d, lo_d} = acc + prod_u;
                  OP_MSUB:  {hi_d, lo_d} = acc - prod_s;
                  OP_MSUBU: {hi_d, lo_d} = acc - prod_u;
                  OP_DIV, OP_DIVU: begin
                     if (b_q != '0) begin
                        lo_d = quo;
                        hi_d = rem;
                     end
                  end
                  default: ;
               endcase
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: default instance plus a WIDTH=16, MULT_LAT=1 instance.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a, b, hi, lo;
   logic [3:0]  md_op;
   logic        start, busy, done;
   logic [15:0] a16, b16, hi16, lo16;
   logic [3:0]  op16;
   logic        start16, busy16, done16;

   int checks = 0;
   int errors = 0;
   logic [63:0] q32[$];
   logic [31:0] q16[$];
   logic [31:0] exp_hi = '0, exp_lo = '0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .A(a), .B(b), .MD_OP(md_op), .START(start),
      .BUSY(busy), .HI(hi), .LO(lo), .DONE(done)
   );

   mult_div_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(3)) dut16 (
      .clk(clk), .reset(reset), .A(a16), .B(b16), .MD_OP(op16), .START(start16),
      .BUSY(busy16), .HI(hi16), .LO(lo16), .DONE(done16)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Result monitors: every DONE pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (q32.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done32 act=%h_%h exp=none", hi, lo);
         end else begin
            logic [63:0] e;
            e = q32.pop_front();
            if ({hi, lo} !== e) begin
               errors++;
               $display("FAIL result32 act=%h_%h exp=%h", hi, lo, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done16 === 1'b1) begin
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done16 act=%h_%h exp=none", hi16, lo16);
         end else begin
            logic [31:0] e;
            e = q16.pop_front();
            if ({hi16, lo16} !== e) begin
               errors++;
               $display("FAIL result16 act=%h_%h exp=%h", hi16, lo16, e);
            end
         end
      end
   end

   // Issue a multi-cycle op; optionally attempt an MTLO while busy.
   task automatic run_op(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                         input int lat, input logic [31:0] nhi, input logic [31:0] nlo,
                         input bit poke);
      int n;
      md_op = op; a = xa; b = xb; start = 1'b1;
      q32.push_back({nhi, nlo});
      tick();
      start = 1'b0; a = ~xa; b = ~xb;
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         chk("hold_hi", 64'(hi), 64'(exp_hi));
         chk("hold_lo", 64'(lo), 64'(exp_lo));
         if (poke && n == 1) begin
            md_op = 4'd6; a = 32'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      chk("latency", 64'(n), 64'(lat));
      chk("done_pulse", 64'(done), 64'd1);
      exp_hi = nhi;
      exp_lo = nlo;
      tick();
      chk("done_clear", 64'(done), 64'd0);
   endtask

   // Single-cycle or ignored ops: BUSY/DONE stay low, model HI/LO updated.
   task automatic mt(input logic [3:0] op, input logic [31:0] xa);
      md_op = op; a = xa; b = 32'h0; start = 1'b1;
      tick();
      start = 1'b0;
      if (op == 4'd5) exp_hi = xa;
      if (op == 4'd6) exp_lo = xa;
      chk("mt_busy", 64'(busy), 64'd0);
      chk("mt_done", 64'(done), 64'd0);
      chk("mt_hi", 64'(hi), 64'(exp_hi));
      chk("mt_lo", 64'(lo), 64'(exp_lo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; md_op = '0; a = '0; b = '0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      tick(); tick();
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      tick();

      run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op(4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
      run_op(4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 1'b0);
      mt(4'd5, 32'd5);
      mt(4'd6, 32'd6);
      run_op(4'd8, 32'hFFFFFFFF, 32'd2, 5, 32'd7, 32'd4, 1'b0);
      mt(4'd5, 32'h11);
      mt(4'd6, 32'h22);
      run_op(4'd3, 32'd1234, 32'd0, 10, 32'h11, 32'h22, 1'b0);
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);
      run_op(4'd9, 32'd2, 32'd3, 5, 32'd0, 32'h7FFFFFFA, 1'b0);
      run_op(4'd7, 32'hFFFFFFFF, 32'd1, 5, 32'd0, 32'h7FFFFFF9, 1'b0);
      run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_op(4'd10, 32'd1, 32'd2, 5, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      run_op(4'd1, 32'd4, 32'd5, 5, 32'd0, 32'h14, 1'b1);
      mt(4'd0, 32'h99);
      mt(4'd11, 32'h99);

      // Reset two cycles into a MULT aborts it with no DONE.
      md_op = 4'd1; a = 32'd3; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_hi = '0; exp_lo = '0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("abort_no_done", 64'(done), 64'd0);
      end

      // Reset wins over a simultaneous MTHI.
      mt(4'd5, 32'h77);
      reset = 1'b1; md_op = 4'd5; a = 32'h55; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      chk("rst_prio_hi", 64'(hi), 64'd0);
      tick();
      chk("rst_prio_busy", 64'(busy), 64'd0);

      // Narrow instance, single-cycle multiply.
      op16 = 4'd2; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
      q16.push_back({16'hFFFE, 16'h0001});
      tick();
      start16 = 1'b0; a16 = '0; b16 = '0;
      chk("w16_busy", 64'(busy16), 64'd1);
      tick();
      chk("w16_busy_clear", 64'(busy16), 64'd0);
      chk("w16_done", 64'(done16), 64'd1);
      tick();
      chk("w16_done_clear", 64'(done16), 64'd0);

      tick();
      chk("q32_drained", 64'(q32.size()), 64'd0);
      chk("q16_drained", 64'(q16.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
